// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one instruction-bus request at a time
// and hands {pc, pc+4, instr, adel} bundles to the decode register.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [31:0] ireq_addr,
   input  logic        ireq_ready,
   input  logic        iresp_valid,
   input  logic [31:0] iresp_data,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_pcplus4,
   output logic [31:0] out_instr,
   output logic        out_adel,
   input  logic        stallF,
   input  logic        is_jump,
   input  logic        is_jr,
   input  logic        branch_taken,
   input  logic [31:0] pcjump,
   input  logic [31:0] pcjr,
   input  logic [31:0] pcbranch,
   input  logic        flush,
   input  logic [31:0] flush_pc
);

   localparam logic [1:0] S_REQ   = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_instr;
   logic [31:0] w_instr_nxt;
   logic [31:0] w_pc_seq;
   logic [31:0] w_pc_redirect;
   logic        w_misaligned;
   logic        w_out_valid;
   logic        w_xfer;

   assign w_misaligned = (r_pc[1:0] != 2'b00);
   assign w_pc_seq     = r_pc + 32'd4;
   assign w_xfer       = w_out_valid & ~stallF;
   assign out_valid    = w_out_valid;
   assign out_pc       = r_pc;
   assign out_pcplus4  = w_pc_seq;
   assign ireq_addr    = r_pc;

   // Decode-resolved next PC, applied only when a bundle actually transfers.
   always_comb begin
      w_pc_redirect = w_pc_seq;
      if (is_jr) begin
         w_pc_redirect = pcjr;
      end else if (is_jump) begin
         w_pc_redirect = pcjump;
      end else if (branch_taken) begin
         w_pc_redirect = pcbranch;
      end else begin
         w_pc_redirect = w_pc_seq;
      end
   end

   // Bus request and bundle presentation; a flush cycle never shows a bundle or issues a
   // request, so a request accepted under flush can never leave an orphan response.
   always_comb begin
      ireq_valid  = 1'b0;
      w_out_valid = 1'b0;
      out_instr   = 32'h0000_0000;
      out_adel    = 1'b0;
      case (r_state)
         S_REQ: begin
            if (w_misaligned) begin
               w_out_valid = ~flush;
               out_adel    = ~flush;
            end else begin
               ireq_valid  = ~flush;
            end
         end
         S_WAIT: begin
            w_out_valid = iresp_valid & ~flush;
            out_instr   = iresp_data;
         end
         S_HOLD: begin
            w_out_valid = ~flush;
            out_instr   = r_instr;
         end
         S_DRAIN: begin
            w_out_valid = 1'b0;
         end
         default: begin
            w_out_valid = 1'b0;
         end
      endcase
   end

   // Next state, PC and latched instruction.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_instr_nxt = r_instr;
      if (flush) begin
         w_pc_nxt = flush_pc;
         case (r_state)
            S_WAIT, S_DRAIN: begin
               w_state_nxt = iresp_valid ? S_REQ : S_DRAIN;
            end
            default: begin
               w_state_nxt = S_REQ;
            end
         endcase
      end else begin
         case (r_state)
            S_REQ: begin
               if (w_xfer) begin
                  w_pc_nxt = w_pc_redirect;
               end else if (!w_misaligned && ireq_ready) begin
                  w_state_nxt = S_WAIT;
               end else begin
                  w_state_nxt = S_REQ;
               end
            end
            S_WAIT: begin
               if (w_xfer) begin
                  w_pc_nxt    = w_pc_redirect;
                  w_state_nxt = S_REQ;
               end else if (iresp_valid) begin
                  w_instr_nxt = iresp_data;
                  w_state_nxt = S_HOLD;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end
            S_HOLD: begin
               if (w_xfer) begin
                  w_pc_nxt    = w_pc_redirect;
                  w_state_nxt = S_REQ;
               end else begin
                  w_state_nxt = S_HOLD;
               end
            end
            S_DRAIN: begin
               if (iresp_valid) begin
                  w_state_nxt = S_REQ;
               end else begin
                  w_state_nxt = S_DRAIN;
               end
            end
            default: begin
               w_state_nxt = S_REQ;
            end
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_REQ;
         r_pc    <= RESET_PC;
         r_instr <= 32'h0000_0000;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_instr <= w_instr_nxt;
      end
   end

endmodule
